// File: rtl/button_conditioner_if.sv
// Button/command bundle between the raw pushbutton front end and the
// consumer of the conditioned UP/DOWN commands.
//   BTN_UP, BTN_DOWN : raw active-low buttons (driven by the master side)
//   UP, DOWN         : one-cycle command pulses (driven by the slave side)
//   busy             : arbiter not idle (driven by the slave side)
interface button_conditioner_if;
    logic BTN_UP;
    logic BTN_DOWN;
    logic UP;
    logic DOWN;
    logic busy;

    modport master (
        output BTN_UP,
        output BTN_DOWN,
        input  UP,
        input  DOWN,
        input  busy
    );

    modport slave (
        input  BTN_UP,
        input  BTN_DOWN,
        output UP,
        output DOWN,
        output busy
    );
endinterface

// File: rtl/button_conditioner.sv
// Conditions two raw active-low pushbuttons into one-cycle UP/DOWN command
// pulses: per-button two-flop synchroniser, debounce filter, press-edge
// detect, then a combo arbiter that turns two presses within COMBO_WINDOW
// cycles into a single UP=DOWN=1 cycle.
//   clk   : system clock
//   RESET : synchronous reset, active-high
//   bus   : slave side of button_conditioner_if (BTN_UP/BTN_DOWN in,
//           UP/DOWN/busy out, all outputs registered)
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int COMBO_WINDOW    = 8
) (
    input  logic                  clk,
    input  logic                  RESET,
    button_conditioner_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DN = 2'd1,
        WAIT_UP = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int WIN_W = (COMBO_WINDOW > 1) ? $clog2(COMBO_WINDOW) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(COMBO_WINDOW - 1);

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]      raw;
    logic [1:0]      meta_q;
    logic [1:0]      sync_q;
    logic [1:0]      pressed;
    logic [1:0]      stable_q;
    logic [1:0]      stable_prev_q;
    logic [DB_W-1:0] cnt_q [2];
    logic [1:0]      press_evt;

    state_t          state_q;
    logic [WIN_W-1:0] timer_q;
    logic            up_q;
    logic            dn_q;
    logic            busy_q;

    assign raw       = {bus.BTN_DOWN, bus.BTN_UP};
    assign pressed   = ~sync_q;
    assign press_evt = stable_q & ~stable_prev_q;

    // Synchroniser and debounce. Flops reset to the released raw level (1)
    // so a button held through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (RESET) begin
            meta_q        <= 2'b11;
            sync_q        <= 2'b11;
            stable_q      <= 2'b00;
            stable_prev_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            meta_q        <= raw;
            sync_q        <= meta_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 2; i++) begin
                if (pressed[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    stable_q[i] <= pressed[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Combo arbiter. Pulses are emitted only on the transition into HOLD,
    // and HOLD waits for both buttons released, so a pulse can never repeat
    // on consecutive cycles. busy_q tracks the state being entered.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= IDLE;
            timer_q <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            up_q <= 1'b0;
            dn_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press_evt[0] && press_evt[1]) begin
                        up_q    <= 1'b1;
                        dn_q    <= 1'b1;
                        state_q <= HOLD;
                        busy_q  <= 1'b1;
                    end else if (press_evt[0]) begin
                        timer_q <= '0;
                        state_q <= WAIT_DN;
                        busy_q  <= 1'b1;
                    end else if (press_evt[1]) begin
                        timer_q <= '0;
                        state_q <= WAIT_UP;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                WAIT_DN: begin
                    busy_q <= 1'b1;
                    if (press_evt[1]) begin
                        up_q    <= 1'b1;
                        dn_q    <= 1'b1;
                        state_q <= HOLD;
                    end else if (!stable_q[0] || timer_q == WIN_LAST) begin
                        up_q    <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        timer_q <= timer_q + WIN_W'(1);
                    end
                end
                WAIT_UP: begin
                    busy_q <= 1'b1;
                    if (press_evt[0]) begin
                        up_q    <= 1'b1;
                        dn_q    <= 1'b1;
                        state_q <= HOLD;
                    end else if (!stable_q[1] || timer_q == WIN_LAST) begin
                        dn_q    <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        timer_q <= timer_q + WIN_W'(1);
                    end
                end
                HOLD: begin
                    if (stable_q == 2'b00) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.UP   = up_q;
    assign bus.DOWN = dn_q;
    assign bus.busy = busy_q;

endmodule
